// File: rtl/hilo_div_seq.sv
// Iterative radix-2 restoring divider sequencer for the DIV/DIVU -> HI/LO path.
// Latency: start accepted in cycle 0, result_valid in cycle WIDTH+3 (IDLE, PREP, WIDTH x RUN, FIX, DONE).
// Backpressure: stall holds IF/ID/EX from the accept cycle until DONE; cancel aborts with no write.
//
// Ports:
//   clk, resetn          - rising-edge clock, asynchronous active-low reset
//   start, signed_div    - divide request from EX (held while stalled), 1 = signed DIV
//   dividend, divisor    - rs / rt operands, sampled when start is accepted in IDLE
//   cancel               - pipeline flush; returns to IDLE, suppresses hi_we/lo_we in DONE
//   stall, busy          - pipeline freeze / divider occupied (PREP, RUN, FIX)
//   result_valid         - one-cycle pulse in DONE; hi_we/lo_we follow it unless cancelled
//   hi_out, lo_out       - remainder / quotient, held until the next completed divide
//
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor seen in IDLE jumps straight to DONE,
// giving the divide-by-zero result one cycle after accept. Undefined: full-length path.

module hilo_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_we,
    output logic             lo_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sgn;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] dvd_raw;   // kept unmodified: divide-by-zero returns it as HI
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // One restoring step. rem < dvs always holds, so the shifted remainder fits in
    // WIDTH+1 bits and the top bit of the difference is a clean borrow flag.
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs};

    assign stall = ((state == S_IDLE) && start && !cancel) || busy;
    assign hi_we = result_valid && !cancel;
    assign lo_we = result_valid && !cancel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            sgn          <= 1'b0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            dvd_raw      <= '0;
            dvs          <= '0;
            quo          <= '0;
            rem          <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            hi_out       <= '0;
            lo_out       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    result_valid <= 1'b0;
                    if (start && !cancel) begin
                        dvd_raw <= dividend;
                        dvs     <= divisor;
                        sgn     <= signed_div;
`ifdef DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            hi_out       <= dividend;
                            lo_out       <= '1;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_PREP;
                        end
`else
                        busy  <= 1'b1;
                        state <= S_PREP;
`endif
                    end
                end

                S_PREP: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        // Magnitudes go through the unsigned core; signs are restored in FIX.
                        quo   <= (sgn && dvd_raw[WIDTH-1]) ? -dvd_raw : dvd_raw;
                        dvs   <= (sgn && dvs[WIDTH-1]) ? -dvs : dvs;
                        q_neg <= sgn && (dvd_raw[WIDTH-1] ^ dvs[WIDTH-1]);
                        r_neg <= sgn && dvd_raw[WIDTH-1];
                        rem   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (trial[WIDTH]) begin
                            rem <= rem_sh[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end else begin
                            rem <= trial[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= S_FIX;
                        end
                    end
                end

                S_FIX: begin
                    busy <= 1'b0;
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        if (dvs == '0) begin
                            hi_out <= dvd_raw;
                            lo_out <= '1;
                        end else begin
                            hi_out <= r_neg ? -rem : rem;
                            lo_out <= q_neg ? -quo : quo;
                        end
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end
                end

                S_DONE: begin
                    // start is ignored here: the pipeline only advances at this edge.
                    result_valid <= 1'b0;
                    state        <= S_IDLE;
                end

                default: begin
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/hilo_div_seq.md
Name: hilo_div_seq

Overview:
- Multi-cycle sequencer for the DIV/DIVU path that feeds the HI/LO register pair.
- Sits beside the EX stage and owns an iterative radix-2 restoring divider.
- Accepts a start pulse from the decoded DIV/DIVU instruction and stalls the pipeline while it iterates.
- Delivers quotient to LO and remainder to HI with single-cycle write enables, matching the hi_mdr/lo_mdr "div" source select.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
resetn  input  1  asynchronous active-low reset.
start  input  1  DIV/DIVU in EX requesting a divide; held high by the stalled pipeline.
signed_div  input  1  1 = DIV (signed), 0 = DIVU.
dividend  input  WIDTH  rs operand, sampled on accepted start.
divisor  input  WIDTH  rt operand, sampled on accepted start.
cancel  input  1  pipeline flush; aborts any operation in flight.
stall  output  1  freezes IF/ID/EX while the divide is pending.
busy  output  1  high in PREP, RUN, FIX.
result_valid  output  1  one-cycle pulse in DONE.
hi_out  output  WIDTH  remainder, stable during DONE.
lo_out  output  WIDTH  quotient, stable during DONE.
hi_we  output  1  equals result_valid.
lo_we  output  1  equals result_valid.

Behaviour:
- Reset: state IDLE; stall=0, busy=0, result_valid=0, hi_we=lo_we=0; hi_out=lo_out=0; counter=0.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - start & !cancel -> latch operands and signed_div, go to PREP.
  - stall is combinationally high in this cycle.
- PREP (1 cycle):
  - If signed, take absolute values.
  - Record q_neg = sign(dividend) ^ sign(divisor) and r_neg = sign(dividend).
  - Clear the partial remainder; counter = WIDTH.
- RUN (WIDTH cycles):
  - Each cycle: shift {rem, quo} left by 1, trial-subtract the divisor, set the quotient LSB.
  - Decrement counter; on counter reaching 1 -> FIX.
- FIX (1 cycle):
  - Negate quotient if q_neg; negate remainder if r_neg.
  - Skipped (values passed raw) when the divisor is zero.
- DONE (1 cycle):
  - result_valid=hi_we=lo_we=1, stall=0; pipeline advances at this edge.
  - start is ignored in DONE; next state IDLE.
- Latency: start accepted at cycle 0; result_valid at cycle WIDTH+3 (35 for WIDTH=32).
- stall = (IDLE & start & !cancel) | busy.
- Arithmetic rules:
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no trap.
  - Divide by zero, signed or unsigned: lo=all ones, hi=dividend as latched (raw, unnegated).
- cancel:
  - In any non-IDLE state, forces IDLE on the next edge with no write enables.
  - In DONE, suppresses hi_we/lo_we combinationally.
  - Takes priority over start.
- Reset mid-operation: immediate return to the reset values; no partial write.
- hi_out/lo_out hold their last result until the next FIX.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined: in IDLE with start and divisor==0, go directly to DONE. result_valid is at cycle 1 with lo=all ones, hi=dividend; stall is high only in the accept cycle.
- Undefined: divide-by-zero takes the full WIDTH+3-cycle path with identical result values.

Test Plan:
- Unsigned 100 / 7, signed_div=0 -> result_valid at cycle 35; lo=14, hi=2; stall high cycles 0–34, low in 35.
- Signed -7 / 2 (0xFFFFFFF9 / 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Unsigned 5 / 0 -> lo=0xFFFFFFFF, hi=5 at cycle 35 (cycle 1 with DIV_ZERO_FAST_EN).
- cancel asserted at RUN cycle 10 -> IDLE next cycle; stall=0; no hi_we/lo_we pulse; a new start two cycles later completes normally.
- resetn pulsed low mid-RUN, then a back-to-back start immediately after DONE -> all outputs return to reset values; the second divide is accepted in IDLE and produces exactly one result_valid pulse.
